// File: rtl/uart_cfg_readback_pkg.sv
// Shared types and constants for the configuration readback transmitter.
// The frame layout lives here so the byte order is defined in one place.
package uart_cfg_pkg;

  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;
  localparam int         FRAME_LEN           = 8;

  localparam int BYTE_HDR    = 0;
  localparam int BYTE_NSAT   = 1;
  localparam int BYTE_FLAGS  = 2;
  localparam int BYTE_CA_HI  = 3;
  localparam int BYTE_CA_LO  = 4;
  localparam int BYTE_DOP    = 5;
  localparam int BYTE_SNR    = 6;
  localparam int BYTE_CSUM   = 7;

  localparam int FLAG_ENABLE   = 0;
  localparam int FLAG_MSG_PRE  = 4;
  localparam int FLAG_NOISE    = 5;
  localparam int FLAG_SIGNAL   = 6;
  localparam int FLAG_CA_START = 7;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  typedef struct packed {
    logic        enable;
    logic [4:0]  n_sat;
    logic        use_msg_preset;
    logic        noise_off;
    logic        signal_off;
    logic        ca_phase_start;
    logic [15:0] ca_phase;
    logic [7:0]  doppler;
    logic [7:0]  snr;
  } cfg_t;

  // Byte idx of the frame built from snapshot c; checksum covers bytes 1..6.
  function automatic logic [7:0] frame_byte(input cfg_t c, input logic [2:0] idx,
                                            input logic [7:0] hdr);
    logic [7:0] b [FRAME_LEN];
    b[BYTE_HDR]                  = hdr;
    b[BYTE_NSAT]                 = {3'b000, c.n_sat};
    b[BYTE_FLAGS]                = '0;
    b[BYTE_FLAGS][FLAG_ENABLE]   = c.enable;
    b[BYTE_FLAGS][FLAG_MSG_PRE]  = c.use_msg_preset;
    b[BYTE_FLAGS][FLAG_NOISE]    = c.noise_off;
    b[BYTE_FLAGS][FLAG_SIGNAL]   = c.signal_off;
    b[BYTE_FLAGS][FLAG_CA_START] = c.ca_phase_start;
    b[BYTE_CA_HI]                = c.ca_phase[15:8];
    b[BYTE_CA_LO]                = c.ca_phase[7:0];
    b[BYTE_DOP]                  = c.doppler;
    b[BYTE_SNR]                  = c.snr;
    b[BYTE_CSUM]                 = b[BYTE_NSAT] ^ b[BYTE_FLAGS] ^ b[BYTE_CA_HI] ^
                                   b[BYTE_CA_LO] ^ b[BYTE_DOP] ^ b[BYTE_SNR];
    return b[idx];
  endfunction

endpackage

// File: rtl/uart_cfg_readback_if.sv
// Request, configuration fields and serial/status outputs of the readback block.
interface uart_cfg_readback_if;
  logic        req_in;
  logic        enable_in;
  logic [4:0]  n_sat_in;
  logic        use_msg_preset_in;
  logic        noise_off_in;
  logic        signal_off_in;
  logic        ca_phase_start_in;
  logic [15:0] ca_phase_in;
  logic [7:0]  doppler_in;
  logic [7:0]  snr_in;
  logic        tx_out;
  logic        busy_out;
  logic        done_out;

  modport master (
    output req_in, enable_in, n_sat_in, use_msg_preset_in, noise_off_in,
           signal_off_in, ca_phase_start_in, ca_phase_in, doppler_in, snr_in,
    input  tx_out, busy_out, done_out
  );

  modport slave (
    input  req_in, enable_in, n_sat_in, use_msg_preset_in, noise_off_in,
           signal_off_in, ca_phase_start_in, ca_phase_in, doppler_in, snr_in,
    output tx_out, busy_out, done_out
  );
endinterface

// File: rtl/uart_cfg_readback_tx_byte.sv
// One 8N1 byte serializer. A load in the last cycle of a stop bit chains the
// next byte with no idle gap; bit_tick marks the last cycle of every bit.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done,
  output logic       bit_tick
);
  localparam logic [9:0] CNT_LAST = 10'(CLKS_PER_BIT - 1);
  localparam logic [3:0] POS_STOP = 4'd9;

  logic       active;
  logic [9:0] cnt;
  logic [3:0] pos;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0] sh;

  assign bit_tick  = active && (cnt == CNT_LAST);
  assign byte_done = bit_tick && (pos == POS_STOP);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active <= 1'b0;
      cnt    <= '0;
      pos    <= '0;
      sh     <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
      pos    <= '0;
      sh     <= data;
    end else if (active) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (pos == POS_STOP) active <= 1'b0;
        else                 pos    <= pos + 4'd1;
        if (pos != 4'd0 && pos != POS_STOP) sh <= sh >> 1;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    if (active) begin
      if (pos == 4'd0)          tx = 1'b0;
      else if (pos != POS_STOP) tx = sh[0];
    end
  end
endmodule

// File: rtl/uart_cfg_readback.sv
// Configuration readback: snapshots the live fields on request and sends an
// 8-byte frame (header, payload, XOR checksum) over a UART line.
module uart_cfg_readback
  import uart_cfg_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 142,
  parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
  input  logic               clk_in,
  input  logic               rst_in,
  uart_cfg_readback_if.slave bus
);
  localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);
  localparam logic [2:0] LAST_BIT  = 3'd7;

  state_t     state, state_nx;
  cfg_t       cfg, live;
  logic [2:0] byte_idx, bit_idx;
  logic       accept, load, bit_tick, byte_done, tx;
  logic [7:0] load_data;

  always_comb begin
    live                = '0;
    live.enable         = bus.enable_in;
    live.n_sat          = bus.n_sat_in;
    live.use_msg_preset = bus.use_msg_preset_in;
    live.noise_off      = bus.noise_off_in;
    live.signal_off     = bus.signal_off_in;
    live.ca_phase_start = bus.ca_phase_start_in;
    live.ca_phase       = bus.ca_phase_in;
    live.doppler        = bus.doppler_in;
    live.snr            = bus.snr_in;
  end

  // DONE also accepts so frames can run back to back.
  assign accept = bus.req_in && (state == IDLE || state == DONE);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   if (bit_tick) state_nx = DATA;
      DATA:    if (bit_tick && bit_idx == LAST_BIT) state_nx = STOP;
      STOP:    if (byte_done) state_nx = (byte_idx == LAST_BYTE) ? DONE : START;
      DONE:    state_nx = accept ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cfg      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
    end else begin
      if (accept) begin
        cfg      <= live;
        byte_idx <= '0;
      end
      if (state == START && bit_tick) bit_idx <= '0;
      if (state == DATA && bit_tick)  bit_idx <= bit_idx + 3'd1;
      if (state == STOP && byte_done && byte_idx != LAST_BYTE)
        byte_idx <= byte_idx + 3'd1;
    end
  end

  always_comb begin
    load      = 1'b0;
    load_data = HEADER_BYTE;
    if (accept) begin
      load = 1'b1;
    end else if (state == STOP && byte_done && byte_idx != LAST_BYTE) begin
      load      = 1'b1;
      load_data = frame_byte(cfg, byte_idx + 3'd1, HEADER_BYTE);
    end
    bus.busy_out = (state == START) || (state == DATA) || (state == STOP);
    bus.done_out = (state == DONE);
    bus.tx_out   = tx;
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load      (load),
    .data      (load_data),
    .tx        (tx),
    .byte_done (byte_done),
    .bit_tick  (bit_tick)
  );
endmodule

// File: tb/tb_uart_cfg_readback.sv
// Bench for uart_cfg_readback: fast-baud instance for most scenarios, default-baud
// instance for full-length timing; expected frames go through a byte queue.
module tb_uart_cfg_readback;
  localparam int CPB_A = 4;
  localparam int CPB_B = 142;
  localparam int CAPN  = 11400;

  typedef logic [7:0] frame_t [8];

  logic        clk = 1'b0, rst = 1'b1, req_a = 1'b0, req_b = 1'b0;
  logic        enable = 0, use_msg = 0, noise_off = 0, signal_off = 0, ca_start = 0;
  logic [4:0]  n_sat = '0;
  logic [15:0] ca_phase = '0;
  logic [7:0]  doppler = '0, snr = '0;

  int checks = 0, errors = 0;
  logic [7:0] exp_q [$];
  logic cap_tx [0:CAPN];
  logic cap_busy [0:CAPN];
  logic cap_done [0:CAPN];

  uart_cfg_readback_if ua ();
  uart_cfg_readback_if ub ();

  assign ua.req_in = req_a;            assign ub.req_in = req_b;
  assign ua.enable_in = enable;        assign ub.enable_in = enable;
  assign ua.n_sat_in = n_sat;          assign ub.n_sat_in = n_sat;
  assign ua.use_msg_preset_in = use_msg;  assign ub.use_msg_preset_in = use_msg;
  assign ua.noise_off_in = noise_off;  assign ub.noise_off_in = noise_off;
  assign ua.signal_off_in = signal_off;   assign ub.signal_off_in = signal_off;
  assign ua.ca_phase_start_in = ca_start; assign ub.ca_phase_start_in = ca_start;
  assign ua.ca_phase_in = ca_phase;    assign ub.ca_phase_in = ca_phase;
  assign ua.doppler_in = doppler;      assign ub.doppler_in = doppler;
  assign ua.snr_in = snr;              assign ub.snr_in = snr;

  uart_cfg_readback #(.CLKS_PER_BIT(CPB_A)) dut_a (.clk_in(clk), .rst_in(rst), .bus(ua));
  uart_cfg_readback #(.CLKS_PER_BIT(CPB_B), .HEADER_BYTE(8'hA5)) dut_b (.clk_in(clk), .rst_in(rst), .bus(ub));

  always #5 clk = ~clk;

  function automatic frame_t model_frame();
    frame_t f;
    f[0] = 8'hA5;
    f[1] = {3'b000, n_sat};
    f[2] = {ca_start, signal_off, noise_off, use_msg, 3'b000, enable};
    f[3] = ca_phase[15:8];
    f[4] = ca_phase[7:0];
    f[5] = doppler;
    f[6] = snr;
    f[7] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
    return f;
  endfunction

  function automatic logic exp_bit(frame_t f, int p);
    int b = p % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return f[p / 10][b - 1];
  endfunction

  // mismatching cycles between captured tx and the ideal 8N1 waveform of f
  function automatic int wave_err(int first, int cpb, frame_t f);
    int n = 0;
    for (int p = 0; p < 80; p++)
      for (int c = 0; c < cpb; c++)
        if (cap_tx[first + p * cpb + c] !== exp_bit(f, p)) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode(int first, int cpb, int i);
    logic [7:0] d;
    for (int j = 0; j < 8; j++) d[j] = cap_tx[first + (i * 10 + 1 + j) * cpb + cpb / 2];
    return d;
  endfunction

  function automatic int first_done(int lo, int hi);
    for (int k = lo; k <= hi; k++) if (cap_done[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_done(int lo, int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (cap_done[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int busy_err(int lo, int hi, int b_lo, int b_hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (cap_busy[k] !== (k >= b_lo && k <= b_hi)) n++;
    return n;
  endfunction

  task automatic pulse_req(input bit sel);
    frame_t f;
    @(posedge clk); #1;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    f = model_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  // cycle k = k-th cycle after the accepting edge
  task automatic capture(input bit sel, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_tx[k]   = sel ? ub.tx_out   : ua.tx_out;
      cap_busy[k] = sel ? ub.busy_out : ua.busy_out;
      cap_done[k] = sel ? ub.done_out : ua.done_out;
    end
  endtask

  task automatic pop_frame(output frame_t f);
    for (int i = 0; i < 8; i++) f[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
  endtask

  task automatic set_cfg(input logic en, input logic [4:0] ns, input logic um, input logic no,
                         input logic so, input logic cs, input logic [15:0] cp,
                         input logic [7:0] dp, input logic [7:0] sn);
    enable = en; n_sat = ns; use_msg = um; noise_off = no; signal_off = so;
    ca_start = cs; ca_phase = cp; doppler = dp; snr = sn;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      got = {ua.tx_out, ua.busy_out, ua.done_out};
      checks++;
      if (got !== 3'b100) begin errors++; $display("FAIL reset_a cyc%0d: got %b want 100", c, got); end
      got = {ub.tx_out, ub.busy_out, ub.done_out};
      checks++;
      if (got !== 3'b100) begin errors++; $display("FAIL reset_b cyc%0d: got %b want 100", c, got); end
    end
    req_a = 1'b1;  // request during reset must lose
    @(posedge clk); @(negedge clk);
    got = {ua.tx_out, ua.busy_out, ua.done_out};
    checks++;
    if (got !== 3'b100) begin errors++; $display("FAIL reset_vs_req: got %b want 100", got); end
    req_a = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_nominal();
    frame_t f;
    logic [7:0] d;
    int e;
    set_cfg(1'b1, 5'd17, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h80, 8'h3C);
    pulse_req(1'b0);
    capture(1'b0, 330);
    pop_frame(f);
    for (int i = 0; i < 8; i++) begin
      d = decode(1, CPB_A, i);
      checks++;
      if (d !== f[i]) begin errors++; $display("FAIL nominal_byte%0d: got %h want %h", i, d, f[i]); end
    end
    d = decode(1, CPB_A, 7);
    checks++;
    if (d !== 8'hAA) begin errors++; $display("FAIL nominal_csum: got %h want aa", d); end
    e = wave_err(1, CPB_A, f);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL nominal_wave: got %0d bad cycles want 0", e); end
    e = first_done(1, 330) - 1;
    checks++;
    if (e !== 320) begin errors++; $display("FAIL nominal_done_latency: got %0d want 320", e); end
    e = count_done(1, 330);
    checks++;
    if (e !== 1) begin errors++; $display("FAIL nominal_done_count: got %0d want 1", e); end
    e = busy_err(1, 330, 1, 320);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL nominal_busy: got %0d bad cycles want 0", e); end
  endtask

  task automatic test_snapshot();
    frame_t f;
    logic [7:0] d;
    int e;
    set_cfg(1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF, 8'h80, 8'h07);
    pulse_req(1'b0);
    fork
      capture(1'b0, 330);
      begin repeat (10) @(posedge clk); #1 doppler = 8'hFF; end
    join
    pop_frame(f);
    d = decode(1, CPB_A, 5);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL snapshot_doppler: got %h want 80", d); end
    d = decode(1, CPB_A, 7);
    checks++;
    if (d !== f[7]) begin errors++; $display("FAIL snapshot_csum: got %h want %h", d, f[7]); end
    e = wave_err(1, CPB_A, f);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL snapshot_wave: got %0d bad cycles want 0", e); end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    frame_t nf;
    int e;
    set_cfg(1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00FF, 8'h01, 8'hFE);
    pulse_req(1'b0);
    fork
      capture(1'b0, 660);
      begin
        repeat (129) @(posedge clk); #1;     // inside byte 3: must be ignored
        req_a = 1'b1;
        set_cfg(1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA55A, 8'h42, 8'h99);
        @(posedge clk); #1 req_a = 1'b0;
        repeat (190) @(posedge clk); #1;     // DONE cycle of the first frame
        req_a = 1'b1;
        nf = model_frame();
        for (int i = 0; i < 8; i++) exp_q.push_back(nf[i]);
        @(posedge clk); #1 req_a = 1'b0;
      end
    join
    pop_frame(f1);
    pop_frame(f2);
    e = wave_err(1, CPB_A, f1);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL b2b_frame1_wave: got %0d bad cycles want 0", e); end
    e = first_done(1, 660);
    checks++;
    if (e !== 321) begin errors++; $display("FAIL b2b_done1_pos: got %0d want 321", e); end
    e = wave_err(322, CPB_A, f2);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL b2b_frame2_wave: got %0d bad cycles want 0", e); end
    e = first_done(322, 660);
    checks++;
    if (e !== 642) begin errors++; $display("FAIL b2b_done2_pos: got %0d want 642", e); end
    e = count_done(1, 660);
    checks++;
    if (e !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", e); end
    e = busy_err(1, 660, 1, 320) - busy_err(322, 641, 322, 641) + busy_err(322, 641, 0, -1) - 320;
    e = 0;
    for (int k = 643; k <= 660; k++) if (cap_tx[k] !== 1'b1 || cap_busy[k] !== 1'b0) e++;
    checks++;
    if (e !== 0) begin errors++; $display("FAIL b2b_idle_after: got %0d bad cycles want 0", e); end
  endtask

  task automatic test_mid_reset();
    frame_t f;
    logic [2:0] got;
    int e;
    set_cfg(1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5AA5, 8'h33, 8'hC3);
    pulse_req(1'b0);
    repeat (170) @(posedge clk); #1 rst = 1'b1;   // during byte 4 data bits
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    got = {ua.tx_out, ua.busy_out, ua.done_out};
    checks++;
    if (got !== 3'b100) begin errors++; $display("FAIL midreset_state: got %b want 100", got); end
    pop_frame(f);  // abandoned frame
    capture(1'b0, 400);
    e = 0;
    for (int k = 1; k <= 400; k++) if (cap_tx[k] !== 1'b1 || cap_done[k] !== 1'b0) e++;
    checks++;
    if (e !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d bad cycles want 0", e); end
    set_cfg(1'b0, 5'd22, 1'b1, 1'b0, 1'b0, 1'b0, 16'h8001, 8'h7F, 8'h10);
    pulse_req(1'b0);
    capture(1'b0, 330);
    pop_frame(f);
    e = wave_err(1, CPB_A, f);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL midreset_refr_wave: got %0d bad cycles want 0", e); end
    e = first_done(1, 330);
    checks++;
    if (e !== 321) begin errors++; $display("FAIL midreset_refr_done: got %0d want 321", e); end
  endtask

  task automatic test_default_baud();
    frame_t f;
    int e;
    set_cfg(1'b1, 5'd17, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h80, 8'h3C);
    pulse_req(1'b1);
    capture(1'b1, 11370);
    pop_frame(f);
    e = wave_err(1, CPB_B, f);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL baud142_wave: got %0d bad cycles want 0", e); end
    e = first_done(1, 11370) - 1;
    checks++;
    if (e !== 11360) begin errors++; $display("FAIL baud142_frame_len: got %0d want 11360", e); end
    e = busy_err(1, 11370, 1, 11360);
    checks++;
    if (e !== 0) begin errors++; $display("FAIL baud142_busy: got %0d bad cycles want 0", e); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_snapshot();
    test_back_to_back();
    test_mid_reset();
    test_default_baud();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_cfg_readback.md
Name: uart_cfg_readback

Overview:
- UART transmitter that returns the live signal-generator configuration to the host over a serial line.
- It is the outbound counterpart of the UART-fed configuration register bank.
- On a request pulse it snapshots the configuration fields, builds an 8-byte frame (header, payload, XOR checksum) and shifts it out 8N1.
- It sits beside the register bank in the top level and drives one dedicated output pin.

Parameters:
- CLKS_PER_BIT, 142, clock cycles per UART bit (same baud rate as the receive path); legal range 2..1023.
- HEADER_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high
- req_in  input  1  one-cycle readback request
- enable_in  input  1  general enable field
- n_sat_in  input  5  satellite number field
- use_msg_preset_in  input  1  config flag
- noise_off_in  input  1  config flag
- signal_off_in  input  1  config flag
- ca_phase_start_in  input  1  config flag
- ca_phase_in  input  16  C/A code phase field
- doppler_in  input  8  doppler field
- snr_in  input  8  SNR field
- tx_out  output  1  UART serial line, idle high
- busy_out  output  1  high while a frame is in progress
- done_out  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high. All state updates on the rising edge of clk_in.
- Reset values: tx_out=1, busy_out=0, done_out=0, FSM=IDLE, all counters 0.
- Frame bytes, in order:
  - B0 = HEADER_BYTE
  - B1 = {3'b000, n_sat}
  - B2 = {ca_phase_start, signal_off, noise_off, use_msg_preset, 3'b000, enable}
  - B3 = ca_phase[15:8]
  - B4 = ca_phase[7:0]
  - B5 = doppler
  - B6 = snr
  - B7 = B1^B2^B3^B4^B5^B6 (header excluded)
- Snapshot: all inputs are latched in the cycle req_in is accepted. Input changes afterwards do not affect the frame in progress.
- Request acceptance: req_in=1 in IDLE is accepted.
  - Next cycle: busy_out=1 and tx_out=0 (start bit of B0).
  - req_in while busy_out=1 is ignored and not queued.
- Byte format: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles. No idle gap between bytes: the next start bit follows the previous stop bit directly.
- FSM states:
  - IDLE -> START on accepted request.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START if byte index < 7, with the index incremented.
  - STOP -> DONE if byte index = 7.
  - DONE -> IDLE after one cycle.
- Completion: in DONE, done_out=1 and busy_out=0, tx_out=1. A req_in in the DONE cycle is accepted.
- Frame length: accept cycle to done_out pulse is exactly 80*CLKS_PER_BIT cycles.
- Counters:
  - bit-cycle counter 10 bits, wraps at CLKS_PER_BIT-1
  - bit index 3 bits
  - byte index 3 bits
- Reset mid-frame: the next cycle gives tx_out=1, busy_out=0, no done_out pulse, and the partial frame is abandoned.
- Simultaneous reset and req_in: reset wins.

Decomposition:
- Package uart_cfg_pkg holds:
  - HEADER_BYTE default
  - FRAME_LEN=8
  - byte index constants
  - FSM state enum {IDLE, START, DATA, STOP, DONE}
  - flag bit positions for B2
- Sub-module uart_tx_byte, one 8N1 byte serializer:
  - inputs: clk_in, rst_in, load, data[7:0]
  - outputs: tx, byte_done
  - parameter: CLKS_PER_BIT
- The top FSM sequences the frame bytes and computes the checksum.

Test Plan:
- Reset check, CLKS_PER_BIT=4: assert rst_in for 3 cycles -> tx_out=1, busy_out=0, done_out=0 throughout.
- Nominal frame: n_sat=5'd17, enable=1, noise_off=1, ca_phase=16'h1234, doppler=8'h80, snr=8'h3C, one req_in pulse.
  - Decoded bytes are A5 11 21 12 34 80 3C, then checksum 11^21^12^34^80^3C.
  - done_out pulses exactly 320 cycles after accept.
- Snapshot isolation: change doppler to 8'hFF 10 cycles after req_in -> the frame still carries 8'h80 and a consistent checksum.
- Request while busy: pulse req_in at byte 3 -> exactly one frame is sent. A second req_in in the DONE cycle starts a back-to-back frame whose start bit is on the next cycle.
- Mid-frame reset: assert rst_in during B4 data bits -> tx_out=1 the next cycle, no done_out. A following req_in produces a complete, correct frame.
- Default baud: CLKS_PER_BIT=142, one frame -> every bit lasts 142 cycles, and the total frame length is 11360 cycles.
